// File: rtl/truth_table_seq_pkg.sv
// Shared types and defaults for the truth-table sequencer.
package truth_table_seq_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam int unsigned DefaultNIn    = 4;
  localparam int unsigned DefaultSettle = 1;

endpackage

// File: rtl/tt_result_tracker.sv
// Accumulates mismatch count, first failing vector and (with TT_CAPTURE_EN) the truth table.
module tt_result_tracker
  import truth_table_seq_pkg::*;
#(
  parameter int unsigned N_IN = DefaultNIn
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    sample_en,
  input  logic [N_IN-1:0]         vec,
  input  logic                    f_sop,
  input  logic                    f_pos,
  output logic [N_IN:0]           mismatch_cnt,
  output logic [N_IN-1:0]         first_bad,
  output logic                    first_bad_vld,
  output logic [(1<<N_IN)-1:0]    ttable
);

  localparam logic [N_IN:0] CntOne = (N_IN + 1)'(1);

  logic [N_IN:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] bad_q, bad_d;
  logic            vld_q, vld_d;

  always_comb begin
    cnt_d = cnt_q;
    bad_d = bad_q;
    vld_d = vld_q;
    if (clear) begin
      cnt_d = '0;
      bad_d = '0;
      vld_d = 1'b0;
    end else if (sample_en && (f_sop != f_pos)) begin
      cnt_d = cnt_q + CntOne;
      // Vectors sweep upward, so the first recorded one is also the lowest.
      if (!vld_q) begin
        bad_d = vec;
        vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      bad_q <= '0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bad_q <= bad_d;
      vld_q <= vld_d;
    end
  end

  assign mismatch_cnt  = cnt_q;
  assign first_bad     = bad_q;
  assign first_bad_vld = vld_q;

`ifdef TT_CAPTURE_EN
  logic [(1<<N_IN)-1:0] ttable_q, ttable_d;

  always_comb begin
    ttable_d = ttable_q;
    if (clear) begin
      ttable_d = '0;
    end else if (sample_en) begin
      ttable_d[vec] = f_sop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ttable_q <= '0;
    end else begin
      ttable_q <= ttable_d;
    end
  end

  assign ttable = ttable_q;
`else
  assign ttable = '0;
`endif

endmodule

// File: rtl/truth_table_sequencer.sv
// Exhaustive SOP-vs-POS equivalence sweeper; define TT_CAPTURE_EN to store the truth table.
module truth_table_sequencer
  import truth_table_seq_pkg::*;
#(
  parameter int unsigned N_IN   = DefaultNIn,
  parameter int unsigned SETTLE = DefaultSettle
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 f_sop,
  input  logic                 f_pos,
  output logic [N_IN-1:0]      vec_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      first_bad,
  output logic                 first_bad_vld,
  output logic [(1<<N_IN)-1:0] ttable
);

  localparam int unsigned    CntW       = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [N_IN-1:0] VecOne     = N_IN'(1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pass_q, pass_d;
  logic            clear, sample_en;

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    clear     = 1'b0;
    sample_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          vec_d   = '0;
          cnt_d   = SettleLoad;
          pass_d  = 1'b0;
          clear   = 1'b1;
          state_d = StSettle;
        end
      end
      StSettle: begin
        busy = 1'b1;
        if (cnt_q == CntOne) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StSample: begin
        busy      = 1'b1;
        sample_en = 1'b1;
        if (&vec_q) begin
          state_d = StDone;
        end else begin
          vec_d   = vec_q + VecOne;
          cnt_d   = SettleLoad;
          state_d = StSettle;
        end
      end
      StDone: begin
        done    = 1'b1;
        pass_d  = (mismatch_cnt == '0);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  assign vec_out = vec_q;
  assign pass    = pass_q;

  tt_result_tracker #(
    .N_IN(N_IN)
  ) u_tracker (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .sample_en    (sample_en),
    .vec          (vec_q),
    .f_sop        (f_sop),
    .f_pos        (f_pos),
    .mismatch_cnt (mismatch_cnt),
    .first_bad    (first_bad),
    .first_bad_vld(first_bad_vld),
    .ttable       (ttable)
  );

endmodule
